branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Branch-resolution and run-sequencing block that drives the program counter's control side. It owns the compare flags, resolves conditional relative branches into the PC's `reljump_en`/`E`/`G`/`target` inputs, issues the PC `start` pulse, and reports run completion. It sits between the instruction decoder and the program counter.

## Interface
- `D`, 8: PC / jump-offset width.
- `W`, 8: compare operand width.
- `LUT_AW`, 4: jump-table address width (2^LUT_AW entries).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: run request from the testbench or host.
- `halt` in 1: decoder saw the halt instruction.
- `cmp_en` in 1: compare instruction this cycle.
- `cmp_a`, `cmp_b` in W: unsigned compare operands.
- `br_en` in 1: branch instruction this cycle.
- `br_cond` in 2: condition code; 00 never, 01 EQ, 10 GT, 11 GE.
- `br_idx` in LUT_AW: jump-table index.
- `lut_we` in 1: jump-table write strobe.
- `lut_addr` in LUT_AW: jump-table write address.
- `lut_data` in D: two's-complement offset to write.
- `start` out 1: to PC `start`.
- `reljump_en` out 1: to PC.
- `E`, `G` out 1: gated flags to PC.
- `target` out D: offset to PC.
- `busy` out 1: program running.
- `done` out 1: program finished.
- `taken_cnt` out 8: taken-branch count.

## Operation
- FSM states: IDLE, LAUNCH, RUN, DONE. Reset enters IDLE.
  - IDLE: `req` moves to LAUNCH.
  - LAUNCH: lasts exactly 1 cycle, with `start`=1; then moves to RUN.
  - RUN: `halt` moves to DONE.
  - DONE: `req` moves to LAUNCH.
- `busy`=1 in LAUNCH and RUN. `done`=1 in DONE only.
- Flag register `fe`, `fg`:
  - On `cmp_en` in RUN, `fe` <= (cmp_a==cmp_b) and `fg` <= (cmp_a>cmp_b), unsigned.
  - The flags hold otherwise.
  - LAUNCH clears both flags.
- Branch outputs are combinational and gated by state==RUN and `br_en`:
  - `reljump_en` = 1 when the condition is nonzero.
  - EQ: `E`=fe, `G`=0.
  - GT: `E`=0, `G`=fg.
  - GE: `E`=fe, `G`=fg.
  - Never, or not RUN: `reljump_en`=`E`=`G`=0.
- `target` = lut[br_idx] at all times. It is not gated.
- Taken: a cycle in RUN with `reljump_en`&&(`E`||`G`).
  - `taken_cnt` increments by 1 per taken cycle and saturates at 255.
  - LAUNCH clears it.
- Jump table:
  - `lut_we` writes lut[lut_addr] <= lut_data only in IDLE or DONE.
  - Writes in LAUNCH/RUN are ignored.

## Timing
- Reset values: state IDLE, `fe`=`fg`=0, `taken_cnt`=0, every lut entry = 1 (D'd1). Outputs `start`=`busy`=`done`=`reljump_en`=`E`=`G`=0.
- `start` is registered-state-decoded. It is high for the single cycle after the edge that samples `req` in IDLE or DONE.
- Branch resolution has zero latency: `br_*` inputs in cycle k drive the PC inputs sampled at the end of cycle k.
- Flags update at the edge ending the `cmp_en` cycle and are visible from the next cycle.
  - A `cmp_en` and `br_en` in the same cycle means the branch uses the old flags.
- `halt` and `br_en` in the same RUN cycle: the branch resolves normally that cycle, and the state moves to DONE.
- `cmp_en`, `br_en` and `halt` outside RUN have no effect.
- `req` during LAUNCH/RUN is ignored. `req` held high in DONE relaunches.
- A table write takes effect for `target` the cycle after the write edge. A same-cycle read returns the old value.
- Reset mid-RUN: on the next edge all state returns to reset values, including the lut. `start` is not asserted, because the PC is reset by the shared `reset`.

## Structure
- Package `branch_pkg`: state enum (IDLE, LAUNCH, RUN, DONE) and condition-code constants (COND_NEVER, COND_EQ, COND_GT, COND_GE).
- Sub-module `jump_lut`: 2^LUT_AW × D register file with synchronous write, async read and reset-to-1.
- FSM, flag register, branch gating and counter live in `branch_ctrl`.

## Test plan
- Reset, then `req`=1 for 1 cycle: `start`=1 for exactly one cycle, then `busy`=1, `done`=0, `taken_cnt`=0.
- In IDLE, write lut[3]=8'hFC. In RUN, compare 5,5, then the next cycle BEQ with idx 3: `reljump_en`=1, `E`=1, `G`=0, `target`=FC, `taken_cnt`=1.
- Compare 7,9, then BGT and GE: both give `reljump_en`=1 with `E`=`G`=0, and `taken_cnt` is unchanged.
- Compare 9,7 and BGT in the same cycle as a prior equal compare: the branch sees the old flags (`G`=0). The next cycle BGT gives `G`=1.
- 260 taken branches: `taken_cnt` saturates at 255. Then `halt`: `done`=1. Then `req`: the counter clears, flags clear and `start` pulses.
- `lut_we` during RUN: the entry is unchanged. Assert `reset` mid-RUN: next cycle state is IDLE, lut[3] reads 1 and all outputs are 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch controller: sequencer states and branch condition codes.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] COND_NEVER = 2'b00;
    localparam logic [1:0] COND_EQ    = 2'b01;
    localparam logic [1:0] COND_GT    = 2'b10;
    localparam logic [1:0] COND_GE    = 2'b11;

endpackage

// File: rtl/jump_lut.sv
// Jump-offset table: synchronous write, asynchronous read, every entry resets to 1.
module jump_lut #(
    parameter int unsigned D      = 8,
    parameter int unsigned LUT_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] addr,
    input  logic [D-1:0]      data,
    input  logic [LUT_AW-1:0] idx,
    output logic [D-1:0]      rd
);

    localparam int unsigned DEPTH = 1 << LUT_AW;

    logic [D-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= D'(1);
            end
        end else if (we) begin
            mem[addr] <= data;
        end
    end

    assign rd = mem[idx];

endmodule

// File: rtl/branch_ctrl.sv
// Run sequencer, compare flags and zero-latency branch resolution feeding the program counter.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned D      = 8,
    parameter int unsigned W      = 8,
    parameter int unsigned LUT_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              halt,
    input  logic              cmp_en,
    input  logic [W-1:0]      cmp_a,
    input  logic [W-1:0]      cmp_b,
    input  logic              br_en,
    input  logic [1:0]        br_cond,
    input  logic [LUT_AW-1:0] br_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_addr,
    input  logic [D-1:0]      lut_data,
    output logic              start,
    output logic              reljump_en,
    output logic              E,
    output logic              G,
    output logic [D-1:0]      target,
    output logic              busy,
    output logic              done,
    output logic [7:0]        taken_cnt
);

    state_t state;
    logic   fe;
    logic   fg;
    logic   in_run;
    logic   taken;
    logic   table_we;

    assign in_run   = (state == RUN);
    assign taken    = reljump_en && (E || G);
    assign table_we = lut_we && ((state == IDLE) || (state == DONE));

    jump_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (table_we),
        .addr  (lut_addr),
        .data  (lut_data),
        .idx   (br_idx),
        .rd    (target)
    );

    // Branch gating: only a RUN-cycle branch with a real condition reaches the PC.
    always_comb begin
        reljump_en = 1'b0;
        E          = 1'b0;
        G          = 1'b0;
        if (in_run && br_en) begin
            case (br_cond)
                COND_EQ: begin reljump_en = 1'b1; E = fe; end
                COND_GT: begin reljump_en = 1'b1; G = fg; end
                COND_GE: begin reljump_en = 1'b1; E = fe; G = fg; end
                default: ;
            endcase
        end
    end

    // Sequencer; status outputs are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fe        <= 1'b0;
            fg        <= 1'b0;
            taken_cnt <= 8'd0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (req) begin
                        state     <= LAUNCH;
                        start     <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fe        <= 1'b0;
                        fg        <= 1'b0;
                        taken_cnt <= 8'd0;
                    end
                end
                LAUNCH: begin
                    state <= RUN;
                end
                RUN: begin
                    if (cmp_en) begin
                        fe <= (cmp_a == cmp_b);
                        fg <= (cmp_a > cmp_b);
                    end
                    if (taken && (taken_cnt != 8'hFF)) begin
                        taken_cnt <= taken_cnt + 8'd1;
                    end
                    if (halt) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: driver pushes model predictions, a negedge monitor pops and compares.
module tb_branch_ctrl;

    typedef struct {
        bit       rst, req, halt, cmp_en, br_en, we;
        bit [7:0] a, b, wdata;
        bit [1:0] cond;
        bit [3:0] idx, waddr;
    } stim_t;

    typedef struct {
        bit       start, busy, done, rj, e, g;
        bit [7:0] target, cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0, halt = 1'b0, cmp_en = 1'b0, br_en = 1'b0, lut_we = 1'b0;
    logic [7:0] cmp_a = 8'd0, cmp_b = 8'd0, lut_data = 8'd0;
    logic [1:0] br_cond = 2'd0;
    logic [3:0] br_idx = 4'd0, lut_addr = 4'd0;
    logic       start, reljump_en, E, G, busy, done;
    logic [7:0] target, taken_cnt;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .halt(halt),
        .cmp_en(cmp_en), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .br_en(br_en), .br_cond(br_cond), .br_idx(br_idx),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .start(start), .reljump_en(reljump_en), .E(E), .G(G),
        .target(target), .busy(busy), .done(done), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 launching, 2 running, 3 finished.
    int       m_mode = 0;
    bit       m_fe = 0, m_fg = 0;
    int       m_cnt = 0;
    bit [7:0] m_lut [16];

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("start",      int'(start),      int'(x.start));
            chk("busy",       int'(busy),       int'(x.busy));
            chk("done",       int'(done),       int'(x.done));
            chk("reljump_en", int'(reljump_en), int'(x.rj));
            chk("E",          int'(E),          int'(x.e));
            chk("G",          int'(G),          int'(x.g));
            chk("target",     int'(target),     int'(x.target));
            chk("taken_cnt",  int'(taken_cnt),  int'(x.cnt));
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s.rst = 0; s.req = 0; s.halt = 0; s.cmp_en = 0; s.br_en = 0; s.we = 0;
        s.a = 0; s.b = 0; s.wdata = 0; s.cond = 0; s.idx = 0; s.waddr = 0;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fe = 0; m_fg = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 8'd1;
    endtask

    // Apply one cycle of stimulus, predict this cycle's outputs, then advance the model.
    task automatic step(input stim_t s);
        exp_t x;
        bit   run;
        reset = s.rst; req = s.req; halt = s.halt; cmp_en = s.cmp_en;
        cmp_a = s.a; cmp_b = s.b; br_en = s.br_en; br_cond = s.cond;
        br_idx = s.idx; lut_we = s.we; lut_addr = s.waddr; lut_data = s.wdata;
        run      = (m_mode == 2);
        x.start  = (m_mode == 1);
        x.busy   = (m_mode == 1) || (m_mode == 2);
        x.done   = (m_mode == 3);
        x.rj     = run && s.br_en && (s.cond != 2'd0);
        x.e      = x.rj && (s.cond == 2'd1 || s.cond == 2'd3) && m_fe;
        x.g      = x.rj && (s.cond == 2'd2 || s.cond == 2'd3) && m_fg;
        x.target = m_lut[s.idx];
        x.cnt    = 8'(m_cnt);
        q.push_back(x);
        @(posedge clk);
        if (s.rst) begin
            model_reset();
        end else begin
            if (x.rj && (x.e || x.g) && m_cnt < 255) m_cnt++;
            if (run && s.cmp_en) begin
                m_fe = (s.a == s.b);
                m_fg = (s.a > s.b);
            end
            if (s.we && (m_mode == 0 || m_mode == 3)) m_lut[s.waddr] = s.wdata;
            if ((m_mode == 0 || m_mode == 3) && s.req) begin
                m_mode = 1; m_cnt = 0; m_fe = 0; m_fg = 0;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else if (m_mode == 2 && s.halt) begin
                m_mode = 3;
            end
        end
        #1;
    endtask

    initial begin
        stim_t s;
        model_reset();
        @(posedge clk); #1;
        s = nop(); s.rst = 1; step(s); step(s);

        s = nop(); s.we = 1; s.waddr = 4'd3; s.wdata = 8'hFC; step(s);
        s = nop(); s.idx = 4'd3; step(s);
        s = nop(); s.req = 1; step(s);
        s = nop(); step(s); step(s);

        s = nop(); s.cmp_en = 1; s.a = 5; s.b = 5; step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd1; s.idx = 4'd3; step(s);

        s = nop(); s.cmp_en = 1; s.a = 7; s.b = 9; step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd2; step(s);
        s.cond = 2'd3; step(s);

        s = nop(); s.cmp_en = 1; s.a = 5; s.b = 5; step(s);
        s = nop(); s.cmp_en = 1; s.a = 9; s.b = 7; s.br_en = 1; s.cond = 2'd2; step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd2; step(s);

        s = nop(); s.br_en = 1; s.cond = 2'd2; s.idx = 4'd3;
        for (int i = 0; i < 260; i++) step(s);

        s = nop(); s.we = 1; s.waddr = 4'd3; s.wdata = 8'h11; step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd3; s.idx = 4'd3; s.halt = 1; step(s);
        s = nop(); s.idx = 4'd3; s.req = 1; s.cmp_en = 1; s.br_en = 1; s.cond = 2'd3; step(s);
        s = nop(); step(s); step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd3; step(s);

        for (int i = 0; i < 600; i++) begin
            s = nop();
            s.rst    = ($urandom_range(0, 63) == 0);
            s.req    = ($urandom_range(0, 7) == 0);
            s.halt   = ($urandom_range(0, 15) == 0);
            s.cmp_en = ($urandom_range(0, 2) == 0);
            s.a      = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            s.b      = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            s.br_en  = ($urandom_range(0, 1) == 0);
            s.cond   = 2'($urandom);
            s.idx    = 4'($urandom);
            s.we     = ($urandom_range(0, 3) == 0);
            s.waddr  = 4'($urandom);
            s.wdata  = 8'($urandom);
            step(s);
        end

        s = nop(); s.rst = 1; step(s);
        s = nop(); s.we = 1; s.waddr = 4'd3; s.wdata = 8'hFC; step(s);
        s = nop(); s.req = 1; step(s);
        s = nop(); step(s); step(s);
        s = nop(); s.cmp_en = 1; s.a = 4; s.b = 4; step(s);
        s = nop(); s.rst = 1; s.br_en = 1; s.cond = 2'd1; s.idx = 4'd3; step(s);
        s = nop(); s.br_en = 1; s.cond = 2'd1; s.idx = 4'd3; step(s);
        s = nop(); s.idx = 4'd3; step(s);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
